// File: rtl/tempo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tempo_pkg
// Purpose  : Shared constants, state types and helpers for the tempo AXI4-Lite
//            slave and its beat counter.
// Contents : ADDR_* byte addresses of the four registers, AXI_RESP_OKAY,
//            write/read path state enums, register-index and byte-merge helpers.
// Revision : 1.0 - initial release
// ============================================================================
package tempo_pkg;

  // Byte addresses of the register map; decode uses address bits [3:2].
  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_PERIOD  = 4'h4;
  localparam logic [3:0] ADDR_BPB     = 4'h8;
  localparam logic [3:0] ADDR_SCRATCH = 4'hC;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Word index of a register from its byte address.
  function automatic logic [1:0] reg_index(input logic [3:0] addr);
    return addr[3:2];
  endfunction

  // Replace only the byte lanes enabled by the write strobe.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tempo_beat_counter.sv
`default_nettype none
// ============================================================================
// Module   : tempo_beat_counter
// Purpose  : Counts clock cycles per beat and beats per bar, producing
//            registered single-cycle beat and bar strobes.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            i_enable          - counting enable
//            i_period [31:0]   - cycles per beat (0 treated as 1)
//            i_bpb    [7:0]    - beats per bar (0 treated as 1)
//            i_clear           - restart the cycle count from 0
//            o_beat_tick       - one-cycle strobe per beat
//            o_bar_tick        - strobe on the beat where the index wraps
//            o_beat_index [7:0]- current beat within the bar
// Revision : 1.0 - initial release
// ============================================================================
module tempo_beat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic [31:0] i_period,
  input  logic [7:0]  i_bpb,
  input  logic        i_clear,
  output logic        o_beat_tick,
  output logic        o_bar_tick,
  output logic [7:0]  o_beat_index
);

  logic [31:0] r_cyc_cnt;
  logic [7:0]  r_beat_index;
  logic        r_beat_tick;
  logic        r_bar_tick;

  logic [31:0] w_last_cyc;
  logic [7:0]  w_last_beat;

  // Terminal values for max(PERIOD,1)-1 and max(BPB,1)-1.
  assign w_last_cyc  = (i_period == 32'd0) ? 32'd0 : i_period - 32'd1;
  assign w_last_beat = (i_bpb == 8'd0)     ? 8'd0  : i_bpb - 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt    <= 32'd0;
      r_beat_index <= 8'd0;
      r_beat_tick  <= 1'b0;
      r_bar_tick   <= 1'b0;
    end else if (!i_enable || i_clear) begin
      // Beat index is deliberately held so pausing resumes mid-bar.
      r_cyc_cnt   <= 32'd0;
      r_beat_tick <= 1'b0;
      r_bar_tick  <= 1'b0;
    end else if (r_cyc_cnt == w_last_cyc) begin
      r_cyc_cnt   <= 32'd0;
      r_beat_tick <= 1'b1;
      // >= so a BPB reduced below the current index still wraps cleanly.
      if (r_beat_index >= w_last_beat) begin
        r_beat_index <= 8'd0;
        r_bar_tick   <= 1'b1;
      end else begin
        r_beat_index <= r_beat_index + 8'd1;
        r_bar_tick   <= 1'b0;
      end
    end else begin
      r_cyc_cnt   <= r_cyc_cnt + 32'd1;
      r_beat_tick <= 1'b0;
      r_bar_tick  <= 1'b0;
    end
  end

  assign o_beat_tick  = r_beat_tick;
  assign o_bar_tick   = r_bar_tick;
  assign o_beat_index = r_beat_index;

endmodule
`default_nettype wire

// File: rtl/tempo_axi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tempo_axi_slave
// Purpose  : AXI4-Lite slave holding CTRL/PERIOD/BEATS_PER_BAR/SCRATCH and
//            driving the beat-tick generator for the sequencer and voices.
// Ports    : ACLK, ARESETN            - clock, asynchronous active-low reset
//            S_AXI_AW*/W*/B*          - AXI4-Lite write address/data/response
//            S_AXI_AR*/R*             - AXI4-Lite read address/data
//            beat_tick, bar_tick      - registered one-cycle strobes
//            beat_index [7:0]         - current beat within the bar
// Revision : 1.0 - initial release
// ============================================================================
module tempo_axi_slave
  import tempo_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            beat_tick,
  output logic                            bar_tick,
  output logic [7:0]                      beat_index
);

  localparam logic [1:0] IDX_CTRL   = reg_index(ADDR_CTRL);
  localparam logic [1:0] IDX_PERIOD = reg_index(ADDR_PERIOD);
  localparam logic [1:0] IDX_BPB    = reg_index(ADDR_BPB);

  logic [31:0] r_regs [4];
  logic [31:0] r_rdata;

  wr_state_e   r_wstate, w_wstate_nxt;
  rd_state_e   r_rstate, w_rstate_nxt;

  logic        w_wr_fire;
  logic        w_rd_fire;
  logic        w_bvalid;
  logic        w_rvalid;
  logic [1:0]  w_wsel;
  logic [1:0]  w_rsel;
  logic [31:0] w_wmerged;
  logic        w_clear;
  logic        w_unused;

  assign w_wsel    = reg_index(S_AXI_AWADDR[3:0]);
  assign w_rsel    = reg_index(S_AXI_ARADDR[3:0]);
  assign w_wmerged = apply_wstrb(r_regs[w_wsel], S_AXI_WDATA, S_AXI_WSTRB);

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  // AW and W are accepted together only; READY is gated by ARESETN so nothing
  // is acknowledged while reset is held.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wr_fire    = 1'b0;
    w_bvalid     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (S_AXI_AWVALID && S_AXI_WVALID && ARESETN) begin
          w_wr_fire    = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rd_fire    = 1'b0;
    w_rvalid     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (S_AXI_ARVALID && ARESETN) begin
          w_rd_fire    = 1'b1;
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // ------------------------------------------------------------ register file
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= 32'd0;
    end else if (w_wr_fire) begin
      r_regs[w_wsel] <= w_wmerged;
    end
  end

  // Sampled at the handshake edge, so a same-cycle write is not yet visible.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)       r_rdata <= 32'd0;
    else if (w_rd_fire) r_rdata <= r_regs[w_rsel];
  end

  // Restart the beat phase whenever enable or period actually changes value.
  assign w_clear = w_wr_fire &&
                   ((w_wsel == IDX_CTRL) || (w_wsel == IDX_PERIOD)) &&
                   (w_wmerged != r_regs[w_wsel]);

  // ------------------------------------------------------------ beat counter
  tempo_beat_counter u_beat_counter (
    .clk          (ACLK),
    .rst_n        (ARESETN),
    .i_enable     (r_regs[IDX_CTRL][0]),
    .i_period     (r_regs[IDX_PERIOD]),
    .i_bpb        (r_regs[IDX_BPB][7:0]),
    .i_clear      (w_clear),
    .o_beat_tick  (beat_tick),
    .o_bar_tick   (bar_tick),
    .o_beat_index (beat_index)
  );

  // ---------------------------------------------------------------- outputs
  assign S_AXI_AWREADY = w_wr_fire;
  assign S_AXI_WREADY  = w_wr_fire;
  assign S_AXI_BVALID  = w_bvalid;
  assign S_AXI_BRESP   = AXI_RESP_OKAY;
  assign S_AXI_ARREADY = w_rd_fire;
  assign S_AXI_RVALID  = w_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = AXI_RESP_OKAY;

  // Protection bits, sub-word address bits and unused register bits.
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                      S_AXI_ARADDR[1:0], r_regs[IDX_CTRL][31:1],
                      r_regs[IDX_BPB][31:8]};

endmodule
`default_nettype wire

// File: tb/tb_tempo_axi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_tempo_axi_slave
// Purpose  : Self-checking bench for tempo_axi_slave. Drivers issue AXI
//            traffic; a negedge monitor keeps a behavioural model (register
//            array, response queues, beat phase anchor) and compares outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tempo_axi_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  aw_addr = '0;
  logic [2:0]  aw_prot = '0;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [3:0]  ar_addr = '0;
  logic [2:0]  ar_prot = '0;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic        beat_tick;
  logic        bar_tick;
  logic [7:0]  beat_index;

  int          n_cmp = 0;
  int          n_bad = 0;
  longint      cyc = 0;
  int          ready_mode = 1;  // 0 random, 1 both high, 2 BREADY low, 3 RREADY low

  tempo_axi_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(aw_addr), .S_AXI_AWPROT(aw_prot), .S_AXI_AWVALID(aw_valid),
    .S_AXI_AWREADY(aw_ready),
    .S_AXI_WDATA(w_data), .S_AXI_WSTRB(w_strb), .S_AXI_WVALID(w_valid),
    .S_AXI_WREADY(w_ready),
    .S_AXI_BRESP(b_resp), .S_AXI_BVALID(b_valid), .S_AXI_BREADY(b_ready),
    .S_AXI_ARADDR(ar_addr), .S_AXI_ARPROT(ar_prot), .S_AXI_ARVALID(ar_valid),
    .S_AXI_ARREADY(ar_ready),
    .S_AXI_RDATA(r_data), .S_AXI_RRESP(r_resp), .S_AXI_RVALID(r_valid),
    .S_AXI_RREADY(r_ready),
    .beat_tick(beat_tick), .bar_tick(bar_tick), .beat_index(beat_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // -------------------------------------------------------- reference model
  logic [31:0] m_regs [4];
  logic [1:0]  m_bq [$];
  logic [31:0] m_rq [$];
  logic        m_tick, m_bar;
  logic [7:0]  m_idx;
  longint      m_anchor;       // first cycle of the current beat phase
  logic        e_aw, e_ar, e_bv, e_rv, m_clr, m_en;
  logic [1:0]  m_ws, m_exp_b;
  logic [31:0] m_merged;
  longint      m_p;
  int          m_b;

  initial begin
    for (int i = 0; i < 4; i++) m_regs[i] = 32'd0;
    m_tick = 1'b0; m_bar = 1'b0; m_idx = 8'd0; m_anchor = 0;
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_awready", 32'(aw_ready), 32'd0);
      chk("rst_wready",  32'(w_ready),  32'd0);
      chk("rst_bvalid",  32'(b_valid),  32'd0);
      chk("rst_arready", 32'(ar_ready), 32'd0);
      chk("rst_rvalid",  32'(r_valid),  32'd0);
      chk("rst_rdata",   r_data,        32'd0);
      chk("rst_bresp",   32'(b_resp),   32'd0);
      chk("rst_rresp",   32'(r_resp),   32'd0);
      chk("rst_beat",    32'(beat_tick), 32'd0);
      chk("rst_bar",     32'(bar_tick),  32'd0);
      chk("rst_index",   32'(beat_index), 32'd0);
      for (int i = 0; i < 4; i++) m_regs[i] = 32'd0;
      m_bq.delete(); m_rq.delete();
      m_tick = 1'b0; m_bar = 1'b0; m_idx = 8'd0; m_anchor = cyc + 1;
    end else begin
      e_bv = (m_bq.size() != 0);
      e_rv = (m_rq.size() != 0);
      e_aw = aw_valid && w_valid && !e_bv;
      e_ar = ar_valid && !e_rv;
      chk("awready", 32'(aw_ready), 32'(e_aw));
      chk("wready",  32'(w_ready),  32'(e_aw));
      chk("bvalid",  32'(b_valid),  32'(e_bv));
      chk("arready", 32'(ar_ready), 32'(e_ar));
      chk("rvalid",  32'(r_valid),  32'(e_rv));
      chk("beat_tick",  32'(beat_tick),  32'(m_tick));
      chk("bar_tick",   32'(bar_tick),   32'(m_bar));
      chk("beat_index", 32'(beat_index), 32'(m_idx));
      if (e_rv) begin
        chk("rdata", r_data, m_rq[0]);
        chk("rresp", 32'(r_resp), 32'd0);
      end
      if (e_bv && b_ready) begin
        m_exp_b = m_bq.pop_front();
        chk("bresp", 32'(b_resp), 32'(m_exp_b));
      end
      if (e_rv && r_ready) void'(m_rq.pop_front());
      // Read sees register contents before any same-cycle write.
      if (e_ar) m_rq.push_back(m_regs[ar_addr[3:2]]);
      m_ws = aw_addr[3:2];
      m_merged = m_regs[m_ws];
      for (int i = 0; i < 4; i++) if (w_strb[i]) m_merged[i*8 +: 8] = w_data[i*8 +: 8];
      m_clr = e_aw && (m_ws <= 2'd1) && (m_merged != m_regs[m_ws]);
      m_en  = m_regs[0][0];
      m_p   = (m_regs[1] == 32'd0) ? 64'd1 : longint'(m_regs[1]);
      m_b   = (m_regs[2][7:0] == 8'd0) ? 1 : int'(m_regs[2][7:0]);
      // Ticks fall on anchor + k*P while enabled and the phase is undisturbed.
      if (!m_en || m_clr) begin
        m_tick = 1'b0; m_bar = 1'b0; m_anchor = cyc + 1;
      end else if (((cyc + 1 - m_anchor) % m_p) == 0) begin
        m_tick = 1'b1;
        m_idx  = (int'(m_idx) + 1 >= m_b) ? 8'd0 : m_idx + 8'd1;
        m_bar  = (m_idx == 8'd0);
      end else begin
        m_tick = 1'b0; m_bar = 1'b0;
      end
      if (e_aw) begin
        m_regs[m_ws] = m_merged;
        m_bq.push_back(2'b00);
      end
    end
  end

  // ------------------------------------------------------------ drivers
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: begin b_ready = ($urandom_range(0, 3) != 0); r_ready = ($urandom_range(0, 3) != 0); end
        2: begin b_ready = 1'b0; r_ready = 1'b1; end
        3: begin b_ready = 1'b1; r_ready = 1'b0; end
        default: begin b_ready = 1'b1; r_ready = 1'b1; end
      endcase
    end
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int lead);
    bit ok = 0;
    @(posedge clk); #1;
    aw_valid = 1'b1; aw_addr = a; aw_prot = 3'($urandom_range(0, 7));
    repeat (lead) begin @(posedge clk); #1; end
    w_valid = 1'b1; w_data = d; w_strb = s;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (aw_ready && w_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    else begin
      n_cmp++; n_bad++;
      $display("FAIL write_timeout: addr 0x%0h got no handshake, required within 300 cycles", a);
    end
    aw_valid = 1'b0; w_valid = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a);
    bit ok = 0;
    @(posedge clk); #1;
    ar_valid = 1'b1; ar_addr = a; ar_prot = 3'($urandom_range(0, 7));
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ar_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    else begin
      n_cmp++; n_bad++;
      $display("FAIL read_timeout: addr 0x%0h got no handshake, required within 300 cycles", a);
    end
    ar_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_data(input logic [1:0] sel);
    logic [31:0] d;
    d = $urandom();
    case (sel)
      2'd0: d[0] = ($urandom_range(0, 3) != 0);
      2'd1: d = 32'($urandom_range(0, 6));
      2'd2: d[7:0] = 8'($urandom_range(0, 5));
      default: ;
    endcase
    return d;
  endfunction

  // ------------------------------------------------------------ sequence
  initial begin
    logic [1:0]  sel;
    logic [3:0]  strb;
    logic [31:0] d;
    int          kind;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic register write/read-back.
    axi_write(4'h0, 32'd1, 4'hF, 0);
    axi_write(4'h4, 32'd2, 4'hF, 0);
    axi_write(4'h8, 32'd3, 4'hF, 0);
    axi_write(4'hC, 32'd4, 4'hF, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4));

    // AW ahead of W, BREADY held low; second write blocked, then strobed merge.
    ready_mode = 2;
    fork
      begin
        axi_write(4'hC, 32'h11223344, 4'hF, 3);
        axi_write(4'hC, 32'hAABBCCDD, 4'b0010, 0);
      end
      begin
        repeat (10) @(posedge clk);
        ready_mode = 1;
      end
    join
    axi_read(4'hC);

    // PERIOD=4, BPB=3, enable.
    axi_write(4'h0, 32'd0, 4'hF, 0);
    axi_write(4'h4, 32'd4, 4'hF, 0);
    axi_write(4'h8, 32'd3, 4'hF, 0);
    axi_write(4'h0, 32'd1, 4'hF, 0);
    repeat (30) @(posedge clk);

    // PERIOD=0 ticks every cycle; disabling holds the index.
    axi_write(4'h4, 32'd0, 4'hF, 0);
    repeat (10) @(posedge clk);
    axi_write(4'h0, 32'd0, 4'hF, 0);
    repeat (10) @(posedge clk);

    // Same-cycle read and write of one register.
    repeat (3) @(posedge clk);
    fork
      axi_write(4'hC, 32'h5A5A0F0F, 4'hF, 0);
      axi_read(4'hC);
    join

    // Reset while RVALID is pending and the counter is running.
    axi_write(4'h4, 32'd3, 4'hF, 0);
    axi_write(4'h0, 32'd1, 4'hF, 0);
    ready_mode = 3;
    axi_read(4'h4);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ready_mode = 1;
    axi_write(4'h4, 32'd2, 4'hF, 0);
    axi_write(4'h8, 32'd2, 4'hF, 0);
    axi_write(4'h0, 32'd1, 4'hF, 0);
    repeat (20) @(posedge clk);

    // Randomized traffic.
    ready_mode = 0;
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 2);
      sel  = 2'($urandom_range(0, 3));
      d    = rand_data(sel);
      strb = (sel == 2'd1 || $urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      case (kind)
        0: axi_write({sel, 2'b00}, d, strb, $urandom_range(0, 2));
        1: axi_read({sel, 2'b00});
        default: fork
          axi_write({sel, 2'b00}, d, strb, 0);
          axi_read(4'($urandom_range(0, 3) * 4));
        join
      endcase
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    ready_mode = 1;
    repeat (20) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/tempo_axi_slave.md
# tempo_axi_slave

AXI4-Lite slave register file and beat-tick generator for AudSynth; it is the responder end of the S00_AXI register interface that the AXI master VIP drives. Software programs enable, beat period and beats-per-bar through four 32-bit registers. The block emits single-cycle beat and bar strobes to the sequencer and synth voices.

## Interface
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width; decode uses addr[3:2].
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR in [C_S_AXI_ADDR_WIDTH-1:0]; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
- S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
- S_AXI_ARADDR in [C_S_AXI_ADDR_WIDTH-1:0]; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
- beat_tick  out  1  one-cycle strobe at each beat.
- bar_tick  out  1  one-cycle strobe coincident with beat_tick when the beat index wraps to 0.
- beat_index  out  8  current beat within the bar.

## Operation
- Register map. All registers are read/write, 32 bits, reset 0, and read back exactly as written.
  - 0x0 CTRL: bit0 is enable.
  - 0x4 PERIOD: ACLK cycles per beat.
  - 0x8 BEATS_PER_BAR: only bits [7:0] are used.
  - 0xC SCRATCH.
- Writes honour WSTRB per byte. BRESP and RRESP are always OKAY (2'b00).
- Write path, state machine W_IDLE -> W_RESP:
  - In W_IDLE, when AWVALID and WVALID are both high, pulse AWREADY and WREADY together for one cycle, perform the register write, and move to W_RESP with BVALID=1.
  - In W_RESP, hold BVALID until BREADY is sampled high, then return to W_IDLE.
  - If AW and W arrive on different cycles, neither is accepted until both are present.
  - No new write is accepted while BVALID=1.
- Read path, state machine R_IDLE -> R_DATA:
  - In R_IDLE, when ARVALID is high, pulse ARREADY for one cycle, latch RDATA from the addressed register, and set RVALID=1.
  - RDATA stays stable while RVALID=1. On RREADY, clear RVALID and return to R_IDLE.
- Simultaneous read and write to the same register in one cycle: the read returns the value from before the write.
- Tempo generator:
  - cyc_cnt is 32 bits and counts only while CTRL.enable=1.
  - Effective period P = max(PERIOD, 1).
  - When cyc_cnt == P-1: cyc_cnt returns to 0 and beat_tick is asserted for that cycle.
  - On the same cycle, beat_index increments. It wraps to 0 after max(BEATS_PER_BAR[7:0], 1) - 1, and bar_tick asserts on that wrap.
- A write to CTRL or PERIOD that changes the stored value clears cyc_cnt on the next cycle.
- Clearing enable holds beat_index and zeroes cyc_cnt.
- When enable=0, beat_tick and bar_tick are 0.

## Timing
- Reset values: all AXI READY and VALID outputs are 0, RDATA=0, BRESP/RRESP=0, beat_tick=0, bar_tick=0, beat_index=0, cyc_cnt=0, all registers 0.
- Reset asserted mid-transaction drops any pending BVALID/RVALID immediately; no response is ever delivered for that transaction.
- Write latency: AW/W handshake in cycle N; the register holds the new value in N+1; BVALID is asserted in N+1.
- Read latency: AR handshake in cycle N; RVALID and RDATA are valid in N+1.
- Maximum throughput is one write every 2 cycles and one read every 2 cycles when BREADY/RREADY are held high.
- Beat timing: the first beat_tick comes P cycles after the cycle in which enable is first seen as 1. Thereafter, ticks come every P cycles.
- beat_tick, bar_tick and beat_index are registered outputs.

## Structure
- Package tempo_pkg:
  - address constants ADDR_CTRL, ADDR_PERIOD, ADDR_BPB, ADDR_SCRATCH;
  - AXI_RESP_OKAY;
  - enum types for the write-path states (W_IDLE/W_RESP) and read-path states (R_IDLE/R_DATA).
- Sub-module tempo_beat_counter, containing cyc_cnt, beat_index and the tick generation. It takes enable, period, bpb and clear as inputs.
- The AXI slave logic and the register file stay in the top-level block.

## Test plan
- Write 1, 2, 3, 4 to 0x0, 0x4, 0x8, 0xC, then read all four back -> reads return 1, 2, 3, 4 with RRESP=0 and BRESP=0.
- Drive AWVALID 3 cycles before WVALID, with BREADY held low for 5 cycles -> AWREADY/WREADY pulse only when both valids are present; BVALID stays high until BREADY; no second write is accepted in the meantime.
- Write WSTRB=4'b0010, WDATA=0xAABBCCDD to SCRATCH holding 0x11223344 -> readback is 0x1122CC44.
- Set PERIOD=4, BPB=3, CTRL=1 -> beat_tick every 4 cycles; beat_index sequence 1, 2, 0, 1; bar_tick on every 3rd beat_tick.
- Set PERIOD=0 with enable=1 -> beat_tick asserts every cycle. Clearing enable -> beat_tick is 0 and beat_index holds its value.
- Assert ARESETN low while RVALID=1 and the counter is running -> all outputs return to reset values immediately; the first beat after reset follows the post-reset programming.
